// File: rtl/osd_dp_vc_router.sv
// rtl/osd_dp_vc_router.sv - flit FIFO that replays debug packets on one of two virtual channels
// Optional feature macro: OSD_DP_VC_ROUTER_STORE_FORWARD_EN (hold packets until fully stored)

package osd_dp_vc_router_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_dp_vc_router
  import osd_dp_vc_router_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int EVENT_VC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  dii_flit                in_flit,
  output logic                   in_ready,
  output dii_flit                out_flit,
  output logic [1:0]             out_valid,
  input  logic [1:0]             out_ready,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] THREE    = CW'(3);
  localparam logic          EV_CH    = (EVENT_VC != 0);
  localparam logic          OTHER_CH = !EV_CH;

  typedef enum logic {IDLE, SEND} state_t;

  logic [15:0]   mem_data [DEPTH];
  logic          mem_last [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd1;
  logic [AW-1:0] rd2;
  logic [CW-1:0] count;
  state_t        state;
  state_t        next_state;
  logic          vc_sel;
  logic          vc_cur;
  logic          vc_class;
  logic          push;
  logic          pop;
  logic          routable;
  logic          head_last;

  assign rd1       = rd_ptr + AW'(1);
  assign rd2       = rd_ptr + AW'(2);
  assign head_last = mem_last[rd_ptr];

  // A full FIFO never accepts, even if the head is being popped this cycle
  assign in_ready   = (count != FULL) && !rst;
  assign push       = in_flit.valid && in_ready;
  assign fill_level = count;

  assign out_flit.valid = |out_valid;
  assign out_flit.last  = head_last;
  assign out_flit.data  = mem_data[rd_ptr];

  // Event packets are recognised by the TYPE bits of the third flit, which must belong to the head packet
  always_comb begin
    vc_class = OTHER_CH;
    if ((count >= THREE) && !mem_last[rd_ptr] && !mem_last[rd1] &&
        (mem_data[rd2][15:14] == 2'b10)) begin
      vc_class = EV_CH;
    end
  end

`ifdef OSD_DP_VC_ROUTER_STORE_FORWARD_EN
  logic [CW-1:0] pkt_cnt;

  // Count of packets whose last flit is stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({push && in_flit.last, pop && head_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // A full FIFO without a complete packet releases its head early so it cannot deadlock
  assign routable = (pkt_cnt != '0) || (count == FULL);
`else
  // Cut-through: enough flits to classify, or a short packet already complete
  assign routable = (count >= THREE) ||
                    ((count != '0) && mem_last[rd_ptr]) ||
                    ((count >= CW'(2)) && mem_last[rd1]);
`endif

  // Output FSM: IDLE presents a routable head in the same cycle, so no bubble follows a last pop
  always_comb begin
    next_state = state;
    out_valid  = 2'b00;
    vc_cur     = vc_sel;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (routable) begin
          vc_cur            = vc_class;
          out_valid[vc_cur] = 1'b1;
          pop               = out_ready[vc_cur];
          if (!(pop && head_last)) next_state = SEND;
        end
      end
      SEND: begin
        if (count != '0) begin
          out_valid[vc_sel] = 1'b1;
          pop               = out_ready[vc_sel];
          if (pop && head_last) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and locked channel; vc_cur equals vc_sel outside IDLE so the lock holds for the packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vc_sel <= 1'b0;
    end else begin
      state  <= next_state;
      vc_sel <= vc_cur;
    end
  end

  // Pointers and occupancy; reset discards any stored or partial packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flit storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_flit.data;
      mem_last[wr_ptr] <= in_flit.last;
    end
  end

endmodule

// File: tb/tb_osd_dp_vc_router.sv
// tb/tb_osd_dp_vc_router.sv - directed checks of the VC router
module tb_osd_dp_vc_router;
  import osd_dp_vc_router_pkg::*;

  logic       clk;
  logic       rst;
  dii_flit    in_flit;
  logic       in_ready;
  dii_flit    out_flit;
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [4:0] fill_level;

  int total = 0;
  int bad   = 0;

  osd_dp_vc_router #(.DEPTH(16), .EVENT_VC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs of this cycle, advance to just after the next edge
  task automatic cyc(input string nm, input logic v, input logic l, input logic [15:0] d,
                     input logic [1:0] rdy, input logic exp_rdy, input logic [1:0] exp_ov,
                     input logic [15:0] exp_d, input logic exp_l, input int exp_fill);
    in_flit.valid = v;
    in_flit.last  = l;
    in_flit.data  = d;
    out_ready     = rdy;
    #1;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({nm, ".flit_valid"}, 32'(out_flit.valid), 32'(exp_ov != 2'b00));
    chk({nm, ".fill"}, 32'(fill_level), 32'(exp_fill));
    if (exp_ov != 2'b00) begin
      chk({nm, ".data"}, 32'(out_flit.data), 32'(exp_d));
      chk({nm, ".last"}, 32'(out_flit.last), 32'(exp_l));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sf_data(input int i);
    return (i == 2) ? 16'h4000 : 16'h1000 + 16'(i);
  endfunction

  initial begin
    rst = 1'b1;
    in_flit = '0;
    out_ready = 2'b00;
    @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.fill", 32'(fill_level), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef OSD_DP_VC_ROUTER_STORE_FORWARD_EN
    // 4-flit event packet on channel 1
    cyc("t1r0", 1, 0, 16'hA001, 2'b11, 1, 2'b00, 16'h0,    0, 0);
    cyc("t1r1", 1, 0, 16'hA002, 2'b11, 1, 2'b00, 16'h0,    0, 1);
    cyc("t1r2", 1, 0, 16'h8000, 2'b11, 1, 2'b00, 16'h0,    0, 2);
    cyc("t1r3", 1, 1, 16'hA004, 2'b11, 1, 2'b10, 16'hA001, 0, 3);
    cyc("t1r4", 0, 0, 16'h0,    2'b11, 1, 2'b10, 16'hA002, 0, 3);
    cyc("t1r5", 0, 0, 16'h0,    2'b11, 1, 2'b10, 16'h8000, 0, 2);
    cyc("t1r6", 0, 0, 16'h0,    2'b11, 1, 2'b10, 16'hA004, 1, 1);
    cyc("t1r7", 0, 0, 16'h0,    2'b11, 1, 2'b00, 16'h0,    0, 0);

    // 5-flit control packet then an event packet, only channel 0 ready
    cyc("t2r0",  1, 0, 16'hC001, 2'b01, 1, 2'b00, 16'h0,    0, 0);
    cyc("t2r1",  1, 0, 16'hC002, 2'b01, 1, 2'b00, 16'h0,    0, 1);
    cyc("t2r2",  1, 0, 16'h0000, 2'b01, 1, 2'b00, 16'h0,    0, 2);
    cyc("t2r3",  1, 0, 16'hC004, 2'b01, 1, 2'b01, 16'hC001, 0, 3);
    cyc("t2r4",  1, 1, 16'hC005, 2'b01, 1, 2'b01, 16'hC002, 0, 3);
    cyc("t2r5",  1, 0, 16'hB001, 2'b01, 1, 2'b01, 16'h0000, 0, 3);
    cyc("t2r6",  1, 0, 16'hB002, 2'b01, 1, 2'b01, 16'hC004, 0, 3);
    cyc("t2r7",  1, 1, 16'h8123, 2'b01, 1, 2'b01, 16'hC005, 1, 3);
    cyc("t2r8",  0, 0, 16'h0,    2'b01, 1, 2'b10, 16'hB001, 0, 3);
    cyc("t2r9",  0, 0, 16'h0,    2'b01, 1, 2'b10, 16'hB001, 0, 3);
    cyc("t2r10", 0, 0, 16'h0,    2'b10, 1, 2'b10, 16'hB001, 0, 3);
    cyc("t2r11", 0, 0, 16'h0,    2'b10, 1, 2'b10, 16'hB002, 0, 2);
    cyc("t2r12", 0, 0, 16'h0,    2'b10, 1, 2'b10, 16'h8123, 1, 1);
    cyc("t2r13", 0, 0, 16'h0,    2'b10, 1, 2'b00, 16'h0,    0, 0);

    // 2-flit packet goes to channel 0
    cyc("t3r0", 1, 0, 16'hD001, 2'b11, 1, 2'b00, 16'h0,    0, 0);
    cyc("t3r1", 1, 1, 16'hD002, 2'b11, 1, 2'b00, 16'h0,    0, 1);
    cyc("t3r2", 0, 0, 16'h0,    2'b11, 1, 2'b01, 16'hD001, 0, 2);
    cyc("t3r3", 0, 0, 16'h0,    2'b11, 1, 2'b01, 16'hD002, 1, 1);
    cyc("t3r4", 0, 0, 16'h0,    2'b11, 1, 2'b00, 16'h0,    0, 0);

    // Fill to full, then exactly one pop while a push is refused
    for (int i = 0; i < 16; i++)
      cyc($sformatf("t4fill%0d", i), 1, i == 15, 16'hE000 + 16'(i), 2'b00, 1,
          (i >= 3) ? 2'b01 : 2'b00, 16'hE000, 0, i);
    cyc("t4full",  1, 0, 16'hDEAD, 2'b00, 0, 2'b01, 16'hE000, 0, 16);
    cyc("t4pop",   1, 0, 16'hDEAD, 2'b01, 0, 2'b01, 16'hE000, 0, 16);
    cyc("t4after", 0, 0, 16'h0,    2'b00, 1, 2'b01, 16'hE001, 0, 15);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("t4drain%0d", k), 0, 0, 16'h0, 2'b01, 1, 2'b01,
          16'hE001 + 16'(k), k == 14, 15 - k);
    cyc("t4end", 0, 0, 16'h0, 2'b00, 1, 2'b00, 16'h0, 0, 0);

    // Asynchronous reset while a packet is in SEND
    cyc("t5r0", 1, 0, 16'hF001, 2'b00, 1, 2'b00, 16'h0,    0, 0);
    cyc("t5r1", 1, 0, 16'hF002, 2'b00, 1, 2'b00, 16'h0,    0, 1);
    cyc("t5r2", 1, 0, 16'hF003, 2'b00, 1, 2'b00, 16'h0,    0, 2);
    cyc("t5r3", 0, 0, 16'h0,    2'b00, 1, 2'b01, 16'hF001, 0, 3);
    cyc("t5r4", 0, 0, 16'h0,    2'b00, 1, 2'b01, 16'hF001, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5rst.out_valid", 32'(out_valid), 32'd0);
    chk("t5rst.fill", 32'(fill_level), 32'd0);
    chk("t5rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("t5r5", 1, 0, 16'h9001, 2'b11, 1, 2'b00, 16'h0,    0, 0);
    cyc("t5r6", 1, 0, 16'h9002, 2'b11, 1, 2'b00, 16'h0,    0, 1);
    cyc("t5r7", 1, 1, 16'h8003, 2'b11, 1, 2'b00, 16'h0,    0, 2);
    cyc("t5r8", 0, 0, 16'h0,    2'b11, 1, 2'b10, 16'h9001, 0, 3);
    cyc("t5r9", 0, 0, 16'h0,    2'b11, 1, 2'b10, 16'h9002, 0, 2);
    cyc("t5r10", 0, 0, 16'h0,   2'b11, 1, 2'b10, 16'h8003, 1, 1);
    cyc("t5r11", 0, 0, 16'h0,   2'b11, 1, 2'b00, 16'h0,    0, 0);
`else
    // 6-flit packet, one flit every other cycle: held until its last flit is stored
    for (int i = 0; i < 6; i++) begin
      cyc($sformatf("sf6push%0d", i), 1, i == 5, sf_data(i), 2'b11, 1, 2'b00, 16'h0, 0, i);
      if (i < 5)
        cyc($sformatf("sf6gap%0d", i), 0, 0, 16'h0, 2'b11, 1, 2'b00, 16'h0, 0, i + 1);
    end
    for (int k = 0; k < 6; k++)
      cyc($sformatf("sf6drain%0d", k), 0, 0, 16'h0, 2'b11, 1, 2'b01, sf_data(k), k == 5, 6 - k);
    cyc("sf6end", 0, 0, 16'h0, 2'b11, 1, 2'b00, 16'h0, 0, 0);

    // 20-flit packet exceeds the FIFO and must be released at full
    begin
      int sent = 0;
      int recv = 0;
      int cycles = 0;
      logic first = 1'b1;
      out_ready = 2'b11;
      while (recv < 20 && cycles < 200) begin
        in_flit.valid = (sent < 20);
        in_flit.last  = (sent == 19);
        in_flit.data  = 16'h7000 + 16'(sent);
        #1;
        if (out_valid != 2'b00) begin
          chk($sformatf("sf20.vc%0d", recv), 32'(out_valid), 32'd1);
          if (first) chk("sf20.release_fill", 32'(fill_level), 32'd16);
          first = 1'b0;
          chk($sformatf("sf20.data%0d", recv), 32'(out_flit.data), 32'(16'h7000 + 16'(recv)));
          chk($sformatf("sf20.last%0d", recv), 32'(out_flit.last), 32'(recv == 19));
          recv++;
        end
        if (in_flit.valid && in_ready) sent++;
        @(posedge clk);
        #1;
        cycles++;
      end
      chk("sf20.received", 32'(recv), 32'd20);
      in_flit = '0;
      #1;
      chk("sf20.fill_end", 32'(fill_level), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
